// File: rtl/serial_pattern_tx_if.sv
// Handshake and serial-output bundle for serial_pattern_tx.
// The master drives the requests; the slave (the transmitter) drives the stream and status.
interface serial_pattern_tx_if #(
   parameter int W     = 4,
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
);
   logic             start;
   logic             abort;
   logic [W-1:0]     pattern;
   logic [CNT_W-1:0] repeat_cnt;
   logic [GAP_W-1:0] gap;
   logic             data;
   logic             valid;
   logic             busy;
   logic             ready;
   logic             done;
   logic [CNT_W-1:0] frame_idx;

   modport master (
      output start, abort, pattern, repeat_cnt, gap,
      input  data, valid, busy, ready, done, frame_idx
   );

   modport slave (
      input  start, abort, pattern, repeat_cnt, gap,
      output data, valid, busy, ready, done, frame_idx
   );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a W-bit pattern out MSB first, repeated
// repeat_cnt times with an optional idle gap between frames. All outputs registered.
module serial_pattern_tx #(
   parameter int W     = 4,
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
) (
   input logic               clk,
   input logic               rst,
   serial_pattern_tx_if.slave bus
);
   localparam int BIT_W = $clog2(W);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     shreg_q, shreg_d;
   logic [W-1:0]     pat_q, pat_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [GAP_W-1:0] gap_len_q, gap_len_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic             data_q, data_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             load_next;

   // rem counts frames still to send after the current one; state_q is what the
   // outputs show this cycle, and outputs are registered from the next state.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d   = state_q;
      shreg_d   = shreg_q;
      pat_d     = pat_q;
      bit_d     = bit_q;
      gap_len_d = gap_len_q;
      gap_cnt_d = gap_cnt_q;
      rem_d     = rem_q;
      idx_d     = idx_q;
      load_next = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start && !bus.abort) begin
               pat_d     = bus.pattern;
               shreg_d   = bus.pattern;
               gap_len_d = bus.gap;
               rem_d     = (bus.repeat_cnt == '0) ? '0 : bus.repeat_cnt - CNT_W'(1);
               bit_d     = BIT_W'(W - 1);
               idx_d     = '0;
               state_d   = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (bit_q != '0) begin
               shreg_d = {shreg_q[W-2:0], 1'b0};
               bit_d   = bit_q - BIT_W'(1);
            end else if (rem_q == '0) begin
               state_d = DONE;
            end else if (gap_len_q != '0) begin
               state_d   = GAP;
               gap_cnt_d = gap_len_q - GAP_W'(1);
            end else begin
               load_next = 1'b1;
            end
         end
         GAP: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (gap_cnt_q == '0) begin
               load_next = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end
      endcase

      if (load_next) begin
         shreg_d = pat_q;
         bit_d   = BIT_W'(W - 1);
         rem_d   = rem_q - CNT_W'(1);
         idx_d   = idx_q + CNT_W'(1);
         state_d = SHIFT;
      end

      data_d  = (state_d == SHIFT) && shreg_d[W-1];
      valid_d = (state_d == SHIFT);
      busy_d  = (state_d == SHIFT) || (state_d == GAP);
      ready_d = (state_d == IDLE) || (state_d == DONE);
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         pat_q     <= '0;
         bit_q     <= '0;
         gap_len_q <= '0;
         gap_cnt_q <= '0;
         rem_q     <= '0;
         idx_q     <= '0;
         data_q    <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         pat_q     <= pat_d;
         bit_q     <= bit_d;
         gap_len_q <= gap_len_d;
         gap_cnt_q <= gap_cnt_d;
         rem_q     <= rem_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
      end
   end

   assign bus.data      = data_q;
   assign bus.valid     = valid_q;
   assign bus.busy      = busy_q;
   assign bus.ready     = ready_q;
   assign bus.done      = done_q;
   assign bus.frame_idx = idx_q;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: each transaction expands into a per-cycle
// expected output trace; a negedge monitor pops and compares one record per cycle.
module tb_serial_pattern_tx;
   localparam int W     = 4;
   localparam int CNT_W = 8;
   localparam int GAP_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   serial_pattern_tx_if #(.W(W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

   serial_pattern_tx #(.W(W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct packed {
      logic             data;
      logic             valid;
      logic             busy;
      logic             ready;
      logic             done;
      logic [CNT_W-1:0] idx;
   } exp_t;

   exp_t             exp_q[$];
   exp_t             trace[$];
   int               n_cmp    = 0;
   int               n_bad    = 0;
   logic [CNT_W-1:0] rest_idx = '0;

   function automatic exp_t rec(input logic d, input logic v, input logic b,
                                input logic r, input logic dn, input int idx);
      exp_t e;
      e.data  = d;
      e.valid = v;
      e.busy  = b;
      e.ready = r;
      e.done  = dn;
      e.idx   = CNT_W'(idx);
      return e;
   endfunction

   // One clock: the record describes the outputs seen until the next edge.
   task automatic step(input exp_t e);
      @(posedge clk);
      #1;
      exp_q.push_back(e);
   endtask

   task automatic idle_step();
      step(rec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, int'(rest_idx)));
   endtask

   // Expected cycle stream for one transmission, straight from the frame/gap rules.
   task automatic build(input logic [W-1:0] pat, input int rc, input int g);
      int nf;
      nf = (rc == 0) ? 1 : rc;
      trace.delete();
      for (int f = 0; f < nf; f++) begin
         for (int b = W - 1; b >= 0; b--)
            trace.push_back(rec(pat[b], 1'b1, 1'b1, 1'b0, 1'b0, f));
         if (f < nf - 1)
            for (int k = 0; k < g; k++)
               trace.push_back(rec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, f));
      end
      trace.push_back(rec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, nf - 1));
   endtask

   // kill_sel >= 0 interrupts inside SHIFT/GAP: kind 0 = abort, kind 1 = rst.
   task automatic send(input logic [W-1:0] pat, input int rc, input int g,
                       input bit hold, input int kill_sel, input bit kind);
      int nf;
      int kill_at;
      nf = (rc == 0) ? 1 : rc;
      build(pat, rc, g);
      kill_at        = (kill_sel >= 0) ? kill_sel % (trace.size() - 1) : -1;
      bus.pattern    = pat;
      bus.repeat_cnt = CNT_W'(rc);
      bus.gap        = GAP_W'(g);
      bus.start      = 1'b1;
      for (int i = 0; i < trace.size(); i++) begin
         step(trace[i]);
         if (!hold) bus.start = 1'b0;
         bus.pattern    = W'($urandom);
         bus.repeat_cnt = CNT_W'($urandom);
         bus.gap        = GAP_W'($urandom);
         if (i == kill_at) begin
            bus.start = 1'b0;
            if (kind) rst = 1'b1;
            else      bus.abort = 1'b1;
            rest_idx = kind ? '0 : trace[i].idx;
            idle_step();
            rst       = 1'b0;
            bus.abort = 1'b0;
            return;
         end
      end
      rest_idx = CNT_W'(nf - 1);
   endtask

   initial begin : monitor
      exp_t e;
      exp_t got;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e         = exp_q.pop_front();
            got.data  = bus.data;
            got.valid = bus.valid;
            got.busy  = bus.busy;
            got.ready = bus.ready;
            got.done  = bus.done;
            got.idx   = bus.frame_idx;
            n_cmp++;
            if (got !== e) begin
               n_bad++;
               $display("FAIL outputs @%0t: got data=%b valid=%b busy=%b ready=%b done=%b idx=%0d, want data=%b valid=%b busy=%b ready=%b done=%b idx=%0d",
                        $time, got.data, got.valid, got.busy, got.ready, got.done, got.idx,
                        e.data, e.valid, e.busy, e.ready, e.done, e.idx);
            end
         end
      end
   end

   initial begin : stimulus
      bit hold;
      int kill;
      bit kind;
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.pattern    = '0;
      bus.repeat_cnt = '0;
      bus.gap        = '0;
      rst            = 1'b1;
      idle_step();
      idle_step();
      rst = 1'b0;
      idle_step();

      send(4'b1101, 1, 0, 1'b0, -1, 1'b0);
      idle_step();
      idle_step();
      send(4'b1101, 3, 0, 1'b0, -1, 1'b0);
      idle_step();
      send(4'b1011, 2, 3, 1'b0, -1, 1'b0);
      idle_step();
      send(4'b1001, 0, 2, 1'b0, -1, 1'b0);
      idle_step();

      // start held through a frame, then restarted straight out of DONE twice
      send(4'b0101, 2, 1, 1'b1, -1, 1'b0);
      send(4'b1110, 1, 0, 1'b0, -1, 1'b0);
      send(4'b0011, 2, 0, 1'b0, -1, 1'b0);
      idle_step();

      // abort on the 2nd bit of the first frame, then a clean restart
      send(4'b1101, 2, 1, 1'b0, 1, 1'b0);
      idle_step();
      send(4'b1001, 1, 0, 1'b0, -1, 1'b0);
      idle_step();

      // abort beats start while ready, in IDLE and in DONE
      bus.start = 1'b1;
      bus.abort = 1'b1;
      idle_step();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      idle_step();
      send(4'b1100, 1, 0, 1'b0, -1, 1'b0);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      idle_step();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      idle_step();

      // rst in the middle of a gap, then pattern 0110 from its MSB
      send(4'b1011, 2, 3, 1'b0, 5, 1'b1);
      idle_step();
      send(4'b0110, 1, 0, 1'b0, -1, 1'b0);
      idle_step();

      for (int k = 0; k < 40; k++) begin
         hold = ($urandom_range(0, 4) == 0);
         kill = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 1000)) : -1;
         kind = 1'($urandom_range(0, 1));
         send(W'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
              hold, kill, kind);
         if (!hold || kill >= 0)
            repeat ($urandom_range(0, 2)) idle_step();
      end
      send(W'($urandom), 3, 2, 1'b0, -1, 1'b0);
      repeat (3) idle_step();

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d records left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
